and_gate_sweep_ctrl: RTL

- Self-test sequencer for the two-input example_and_gate datapath.
- On a start pulse, drives the gate's two inputs through all four combinations: 00, 01, 10, 11.
- Holds each combination for a programmable number of cycles, then samples and_result and checks it against the expected AND value.
- Reports a per-vector fail mask, a pass flag and a done pulse. Sits between a top-level test/control block and the gate instance.

---
 rtl/and_gate_sweep_ctrl_pkg.sv | 18 +
 rtl/and_gate_sweep_ctrl_hold.sv | 35 +++
 rtl/and_gate_sweep_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/and_gate_sweep_ctrl_pkg.sv
// Shared types and constants for the AND-gate self-test sequencer.
package and_gate_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;
  localparam logic [1:0]  LAST_VEC    = 2'(NUM_VECTORS - 1);

  function automatic logic expected_and(input logic [1:0] vec);
    return vec[1] & vec[0];
  endfunction

endpackage

// File: rtl/and_gate_sweep_ctrl_hold.sv
// Hold counter: counts cycles a vector has been driven and flags the last one.
module sweep_hold_counter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned HCNT_W      = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [HCNT_W-1:0] cnt_q;
  logic [HCNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + HCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == HCNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/and_gate_sweep_ctrl.sv
// Self-test sequencer: sweeps the AND gate inputs through 00,01,10,11 and checks the result.
module and_gate_sweep_ctrl
  import and_gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned HCNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       and_in_1,
  output logic       and_in_2,
  input  logic       and_result,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  state_t     state_q;
  logic       and_in_1_q, and_in_2_q;
  logic       busy_q, done_q, pass_q;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic [1:0] vec_idx_q, vec_next;
  logic       hold_tc;
  logic       in_sweep;

  assign in_sweep = (state_q == DRIVE) || (state_q == SAMPLE);
  assign vec_next = vec_idx_q + 2'd1;

  sweep_hold_counter #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .HCNT_W      (HCNT_W)
  ) u_hold (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i ((state_q != DRIVE) || abort || hold_tc),
    .en_i  (state_q == DRIVE),
    .tc_o  (hold_tc)
  );

  always_comb begin
    fail_mask_d = fail_mask_q;
    if (and_result != expected_and(vec_idx_q)) begin
      fail_mask_d[vec_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      and_in_1_q  <= 1'b0;
      and_in_2_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      vec_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      // Abort drops straight to IDLE; fail bits gathered so far are kept.
      if (abort && in_sweep) begin
        state_q    <= IDLE;
        and_in_1_q <= 1'b0;
        and_in_2_q <= 1'b0;
        busy_q     <= 1'b0;
        pass_q     <= 1'b0;
        vec_idx_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              state_q     <= DRIVE;
              busy_q      <= 1'b1;
              pass_q      <= 1'b0;
              fail_mask_q <= '0;
              vec_idx_q   <= '0;
              and_in_1_q  <= 1'b0;
              and_in_2_q  <= 1'b0;
            end
          end
          DRIVE: begin
            if (hold_tc) begin
              state_q <= SAMPLE;
            end
          end
          SAMPLE: begin
            fail_mask_q <= fail_mask_d;
            if (vec_idx_q == LAST_VEC) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              pass_q     <= (fail_mask_d == '0);
              vec_idx_q  <= '0;
              and_in_1_q <= 1'b0;
              and_in_2_q <= 1'b0;
            end else begin
              state_q    <= DRIVE;
              vec_idx_q  <= vec_next;
              and_in_1_q <= vec_next[1];
              and_in_2_q <= vec_next[0];
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign and_in_1  = and_in_1_q;
  assign and_in_2  = and_in_2_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign vec_idx   = vec_idx_q;

endmodule
